hazard_unit_mc: RTL and testbench

//  Next-gen pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W).

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_unit_mc_if.sv | 39 +++
 rtl/hazard_unit_mc_md_seq.sv | 75 +++++++
 rtl/hazard_unit_mc.sv | 82 ++++++++
 tb/tb_hazard_unit_mc.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller of the 5-stage core.
// Holds the ResultSrc/PCSrc codes the unit decodes, the forwarding-mux
// select encoding and the MUL/DIV sequencer state type.
package hazard_pkg;

    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] PCSRC_BR    = 2'b01;
    localparam logic [1:0] PCSRC_JMP   = 2'b10;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Bundle of every pipeline-to-hazard-unit signal.
//   master : the pipeline datapath; drives register indices and stage
//            controls, receives forward selects, stalls, flushes,
//            sequencer status and perf counters.
//   slave  : the hazard unit itself (opposite directions).
interface hazard_unit_mc_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic [RA_W-1:0]  RS1_E, RS2_E, RD_E, RD_M, RD_W, RS1_D, RS2_D;
    logic             RegWrite_M, RegWrite_W;
    logic [1:0]       ResultSrc_E;
    logic             MulDiv_E;
    logic             MemReq_M, MemReady_M;
    logic [1:0]       PCSrc;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushM, FlushW;
    logic             md_busy, md_done;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output RS1_E, RS2_E, RD_E, RD_M, RD_W, RS1_D, RS2_D,
               RegWrite_M, RegWrite_W, ResultSrc_E, MulDiv_E,
               MemReq_M, MemReady_M, PCSrc,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW, md_busy, md_done,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  RS1_E, RS2_E, RD_E, RD_M, RD_W, RS1_D, RS2_D,
               RegWrite_M, RegWrite_W, ResultSrc_E, MulDiv_E,
               MemReq_M, MemReady_M, PCSrc,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW, md_busy, md_done,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit_mc_md_seq.sv
// MUL/DIV sequencer for the E stage.
// Ports: clk, reset (sync, active-high), MulDiv_E (op in E),
//        mem_stall (data-memory wait state), md_stall (hold F/D/E),
//        md_busy (not idle), md_done (last E cycle, result valid).
// An op occupies E for MD_LAT cycles: the first cycle is seen in IDLE,
// the remaining stall cycles in BUSY, and the final cycle in DONE.
module md_seq
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic MulDiv_E,
    input  logic mem_stall,
    output logic md_stall,
    output logic md_busy,
    output logic md_done
);
    localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((MD_LAT > 2) ? MD_LAT - 2 : 0);

    md_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;

    // cnt holds the BUSY cycles still to run; BUSY is left on the cycle
    // the count would reach zero, so the IDLE cycle plus BUSY give
    // exactly MD_LAT-1 stalls. With MD_LAT==2 the IDLE cycle alone is
    // the one stall, so BUSY is skipped.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            MD_IDLE: begin
                if (MulDiv_E && !mem_stall && MD_LAT > 1) begin
                    state_n = (MD_LAT == 2) ? MD_DONE : MD_BUSY;
                    cnt_n   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                // Counting continues under mem_stall: the unit keeps working.
                cnt_n = (cnt == '0) ? '0 : cnt - CW'(1);
                if (cnt <= CW'(1))
                    state_n = MD_DONE;
            end
            MD_DONE: begin
                if (!mem_stall)
                    state_n = MD_IDLE;
            end
            default: state_n = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Gated by reset so an abandoned op neither stalls nor reports done.
    assign md_stall = !reset &&
                      ((state == MD_IDLE && MulDiv_E && MD_LAT > 1) ||
                       state == MD_BUSY);
    assign md_busy  = (state != MD_IDLE);
    assign md_done  = !reset && (state == MD_DONE);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the F/D/E/M/W pipeline.
// Ports: clk, reset (sync, active-high), hz (slave side of
// hazard_unit_mc_if: register indices and stage controls in; forward
// selects, stage stalls/flushes, MUL/DIV status and saturating
// stall/flush perf counters out).
// Priority: data-memory wait > MUL/DIV > load-use / redirect.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int RA_W   = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    hazard_unit_mc_if.slave  hz
);
    logic mem_stall, md_stall, stall_e, lwstall, redirect, stall_f;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // M is the younger producer, so it wins over W; x0 never forwards.
    function automatic fwd_sel_t fwd_sel(input logic [RA_W-1:0] rs,
                                         input logic [RA_W-1:0] rd_m,
                                         input logic [RA_W-1:0] rd_w,
                                         input logic            we_m,
                                         input logic            we_w);
        if (rs != '0 && we_m && rs == rd_m)
            return FWD_M;
        else if (rs != '0 && we_w && rs == rd_w)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    md_seq #(.MD_LAT(MD_LAT)) u_md_seq (
        .clk       (clk),
        .reset     (reset),
        .MulDiv_E  (hz.MulDiv_E),
        .mem_stall (mem_stall),
        .md_stall  (md_stall),
        .md_busy   (hz.md_busy),
        .md_done   (hz.md_done)
    );

    assign mem_stall = hz.MemReq_M && !hz.MemReady_M;
    assign stall_e   = mem_stall || md_stall;

    // Load-use and redirect are decided by E; while E is frozen the
    // instruction there has not really executed, so both are suppressed.
    assign lwstall  = (hz.ResultSrc_E == RESULT_LOAD) && (hz.RD_E != '0) &&
                      (hz.RS1_D == hz.RD_E || hz.RS2_D == hz.RD_E) && !stall_e;
    assign redirect = (hz.PCSrc == PCSRC_BR || hz.PCSrc == PCSRC_JMP) && !stall_e;
    assign stall_f  = stall_e || lwstall;

    assign hz.ForwardAE = fwd_sel(hz.RS1_E, hz.RD_M, hz.RD_W, hz.RegWrite_M, hz.RegWrite_W);
    assign hz.ForwardBE = fwd_sel(hz.RS2_E, hz.RD_M, hz.RD_W, hz.RegWrite_M, hz.RegWrite_W);

    assign hz.StallF = stall_f;
    assign hz.StallD = stall_f && !redirect;   // redirected D content is dead anyway
    assign hz.StallE = stall_e;
    assign hz.StallM = mem_stall;
    assign hz.FlushD = redirect;
    assign hz.FlushE = lwstall || redirect;
    assign hz.FlushM = md_stall && !mem_stall; // bubble behind the frozen MUL/DIV
    assign hz.FlushW = mem_stall;              // M not retiring: W gets a bubble

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc. A driver applies one stimulus per
// cycle and pushes the reference-model prediction; a monitor on the
// falling edge pops and compares. A second DUT with CNT_W=2 shares the
// stimulus to exercise counter saturation.
module tb_hazard_unit_mc;
    localparam int RA_W   = 5;
    localparam int MD_LAT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_mc_if #(.RA_W(RA_W), .CNT_W(32)) hz ();
    hazard_unit_mc_if #(.RA_W(RA_W), .CNT_W(2))  hz2 ();

    assign hz2.RS1_E       = hz.RS1_E;
    assign hz2.RS2_E       = hz.RS2_E;
    assign hz2.RD_E        = hz.RD_E;
    assign hz2.RD_M        = hz.RD_M;
    assign hz2.RD_W        = hz.RD_W;
    assign hz2.RS1_D       = hz.RS1_D;
    assign hz2.RS2_D       = hz.RS2_D;
    assign hz2.RegWrite_M  = hz.RegWrite_M;
    assign hz2.RegWrite_W  = hz.RegWrite_W;
    assign hz2.ResultSrc_E = hz.ResultSrc_E;
    assign hz2.MulDiv_E    = hz.MulDiv_E;
    assign hz2.MemReq_M    = hz.MemReq_M;
    assign hz2.MemReady_M  = hz.MemReady_M;
    assign hz2.PCSrc       = hz.PCSrc;

    hazard_unit_mc #(.RA_W(RA_W), .MD_LAT(MD_LAT), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .hz(hz.slave));
    hazard_unit_mc #(.RA_W(RA_W), .MD_LAT(MD_LAT), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .hz(hz2.slave));

    typedef struct {
        logic [4:0] rs1e, rs2e, rde, rdm, rdw, rs1d, rs2d;
        logic       rwm, rww;
        logic [1:0] rsrc;
        logic       md, mreq, mrdy;
        logic [1:0] pcsrc;
        logic       rst;
    } stim_t;

    typedef struct {
        logic [1:0] fa, fb;
        logic       sf, sd, se, sm, fd, fe, fm, fw, busy, done;
        longint     scnt, fcnt, scnt2;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    stim_t  cur, s;
    int     compared   = 0;
    int     mismatched = 0;

    // Reference model: elapsed = E cycles already spent by the current
    // MUL/DIV op (0 = none in flight); totals are unbounded event counts.
    int     elapsed = 0;
    longint n_stall = 0;
    longint n_flush = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input stim_t t);
        if (rs == 0) return 2'b00;
        if (t.rwm && rs == t.rdm) return 2'b10;
        if (t.rww && rs == t.rdw) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t predict(input stim_t t);
        exp_t e;
        logic mem, mds, ste, lw, rd;
        mem = t.mreq && !t.mrdy;
        if (t.rst)             mds = 1'b0;
        else if (elapsed == 0) mds = t.md;
        else                   mds = (elapsed < MD_LAT - 1);
        ste = mem || mds;
        lw  = (t.rsrc == 2'b01) && (t.rde != 0) &&
              (t.rs1d == t.rde || t.rs2d == t.rde) && !ste;
        rd  = (t.pcsrc == 2'b01 || t.pcsrc == 2'b10) && !ste;
        e.fa    = fwd_ref(t.rs1e, t);
        e.fb    = fwd_ref(t.rs2e, t);
        e.sf    = ste || lw;
        e.sd    = (ste || lw) && !rd;
        e.se    = ste;
        e.sm    = mem;
        e.fd    = rd;
        e.fe    = lw || rd;
        e.fm    = mds && !mem;
        e.fw    = mem;
        e.busy  = (elapsed != 0);
        e.done  = !t.rst && (elapsed == MD_LAT - 1);
        e.scnt  = (n_stall > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : n_stall;
        e.fcnt  = (n_flush > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : n_flush;
        e.scnt2 = (n_stall > 3) ? 3 : n_stall;
        return e;
    endfunction

    // Advance the model across the clock edge that ends cycle t.
    task automatic advance(input stim_t t);
        exp_t e;
        logic mem;
        if (t.rst) begin
            elapsed = 0;
            n_stall = 0;
            n_flush = 0;
        end else begin
            e   = predict(t);
            mem = t.mreq && !t.mrdy;
            n_stall += longint'(e.sf);
            n_flush += longint'(e.fd);
            if (elapsed == 0) begin
                if (t.md && !mem) elapsed = 1;
            end else if (elapsed < MD_LAT - 1) begin
                elapsed++;
            end else if (!mem) begin
                elapsed = 0;
            end
        end
    endtask

    task automatic apply(input stim_t t);
        hz.RS1_E = t.rs1e;  hz.RS2_E = t.rs2e;  hz.RD_E = t.rde;
        hz.RD_M = t.rdm;    hz.RD_W = t.rdw;
        hz.RS1_D = t.rs1d;  hz.RS2_D = t.rs2d;
        hz.RegWrite_M = t.rwm;  hz.RegWrite_W = t.rww;
        hz.ResultSrc_E = t.rsrc;  hz.MulDiv_E = t.md;
        hz.MemReq_M = t.mreq;  hz.MemReady_M = t.mrdy;
        hz.PCSrc = t.pcsrc;
        reset = t.rst;
    endtask

    task automatic step(input stim_t t);
        @(posedge clk);
        advance(cur);
        #1;
        apply(t);
        cur = t;
        q.push_back(predict(t));
    endtask

    function automatic stim_t blank();
        stim_t t;
        t = '{default: '0};
        t.mrdy = 1'b1;
        return t;
    endfunction

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            check("ForwardAE", 64'(hz.ForwardAE), 64'(mon_e.fa));
            check("ForwardBE", 64'(hz.ForwardBE), 64'(mon_e.fb));
            check("StallF",    64'(hz.StallF),    64'(mon_e.sf));
            check("StallD",    64'(hz.StallD),    64'(mon_e.sd));
            check("StallE",    64'(hz.StallE),    64'(mon_e.se));
            check("StallM",    64'(hz.StallM),    64'(mon_e.sm));
            check("FlushD",    64'(hz.FlushD),    64'(mon_e.fd));
            check("FlushE",    64'(hz.FlushE),    64'(mon_e.fe));
            check("FlushM",    64'(hz.FlushM),    64'(mon_e.fm));
            check("FlushW",    64'(hz.FlushW),    64'(mon_e.fw));
            check("md_busy",   64'(hz.md_busy),   64'(mon_e.busy));
            check("md_done",   64'(hz.md_done),   64'(mon_e.done));
            check("stall_cnt", 64'(hz.stall_cnt), mon_e.scnt);
            check("flush_cnt", 64'(hz.flush_cnt), mon_e.fcnt);
            check("stall_cnt_sat", 64'(hz2.stall_cnt), mon_e.scnt2);
        end
    end

    initial begin
        cur = blank();
        cur.rst = 1'b1;
        apply(cur);

        // Reset state.
        s = blank(); s.rst = 1'b1;
        repeat (2) step(s);

        // Forwarding priority and x0.
        s = blank();
        s.rs1e = 5; s.rdm = 5; s.rdw = 5; s.rwm = 1; s.rww = 1;
        step(s);
        s.rs1e = 0; s.rs2e = 5; s.rwm = 0;
        step(s);

        // Load-use, then RD_E = x0.
        s = blank();
        s.rsrc = 2'b01; s.rde = 7; s.rs2d = 7;
        step(s);
        s.rde = 0; s.rs2d = 0;
        step(s);

        // Back-to-back MUL/DIV ops with MulDiv_E held.
        s = blank(); s.md = 1;
        repeat (8) step(s);

        // Memory wait during BUSY and while in DONE.
        s = blank(); s.md = 1;
        step(s);
        s.mreq = 1; s.mrdy = 0;
        repeat (3) step(s);
        s.mrdy = 1;
        step(s);
        s = blank();
        step(s);

        // Redirects: clean jump, jump under memory wait, PCSrc=11.
        s = blank(); s.pcsrc = 2'b10;
        step(s);
        s.mreq = 1; s.mrdy = 0;
        step(s);
        s = blank(); s.pcsrc = 2'b11;
        step(s);

        // Reset while BUSY.
        s = blank(); s.md = 1;
        repeat (2) step(s);
        s.rst = 1;
        step(s);
        s = blank();
        repeat (2) step(s);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rs1e  = 5'($urandom_range(0, 3));
            s.rs2e  = 5'($urandom_range(0, 3));
            s.rde   = 5'($urandom_range(0, 3));
            s.rdm   = 5'($urandom_range(0, 3));
            s.rdw   = 5'($urandom_range(0, 3));
            s.rs1d  = 5'($urandom_range(0, 3));
            s.rs2d  = 5'($urandom_range(0, 3));
            s.rwm   = 1'($urandom_range(0, 1));
            s.rww   = 1'($urandom_range(0, 1));
            s.rsrc  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 3) s.md = 1'($urandom_range(0, 1));
            s.mreq  = ($urandom_range(0, 3) == 0);
            s.mrdy  = 1'($urandom_range(0, 1));
            s.pcsrc = 2'($urandom_range(0, 3));
            s.rst   = ($urandom_range(0, 99) < 2);
            step(s);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
